alu_exec_ctrl: RTL and testbench
================================

# alu_exec_ctrl

Execute-stage controller that sits directly upstream of the 8-bit ALU and consumes its result. It accepts one decoded instruction at a time through a valid/ready handshake and reads operands from a 4-entry x 8-bit register file. It drives registered operands, opcode and carry-in to the ALU, then captures the ALU result and flags. It writes the result back and updates the architectural flags register (C, Z, V).

## Interface
- No parameters: data width 8, register count 4, ALU opcode width 4 are fixed.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  decoded instruction present
- instr_ready  out  1  block can accept an instruction (high only in IDLE)
- instr_op  in  4  ALU opcode: 0 AND, 1 OR, 2 XOR, 3 INV, 4 ADD, 5 SUB, 6 INC, 7 DEC, 8 MOV, 9 NOP, 10-15 reserved
- instr_rd  in  2  destination register, also operand A source
- instr_rs  in  2  operand B source register
- instr_use_imm  in  1  1: operand B = instr_imm instead of reg[rs]
- instr_imm  in  8  immediate operand
- instr_use_carry  in  1  1: alu_cin = flag_c, else 0
- alu_a, alu_b  out  8 each  registered ALU operands
- alu_op  out  4  registered ALU opcode
- alu_cin  out  1  registered ALU carry-in
- alu_res  in  8  ALU result
- alu_cout, alu_zero, alu_ovf  in  1 each  ALU flag outputs
- done  out  1  one-cycle pulse: instruction retired
- flag_c, flag_z, flag_v  out  1 each  architectural flags
- load_en  in  1  external register-file write strobe
- load_addr  in  2  external write address
- load_data  in  8  external write data
- dbg_addr  in  2  debug read address
- dbg_data  out  8  combinational read of reg[dbg_addr]

## Operation
- Reset: state IDLE; all four registers 0x00; flags 0; alu_a/alu_b/alu_op/alu_cin 0; done 0; instr_ready 1 (combinational from IDLE). The latched instruction fields also clear to 0.
- FSM states: IDLE, OPER, EXEC, WB. IDLE->OPER on instr_valid & instr_ready. OPER->EXEC, EXEC->WB and WB->IDLE are unconditional.
- IDLE: an accepted instruction latches all instr_* fields. While instr_valid is low, the block holds.
- OPER: loads alu_a <= reg[rd]. Loads alu_b <= use_imm ? imm : reg[rs]. Loads alu_op <= op and alu_cin <= use_carry & flag_c.
- EXEC: ALU inputs are stable. Captures alu_res, alu_cout, alu_zero and alu_ovf into internal result/flag holding registers.
- WB: for ops 0-8, reg[rd] <= captured result and {C,Z,V} <= captured flags. For ops 9-15, there is no register write and the flags are unchanged. done goes high for the cycle after WB.
- alu_* outputs hold their last values outside OPER. They are not cleared between instructions.
- load port: honored in every state. If a WB write and load_en target the same address on the same edge, the WB write wins. Different addresses are both written. A load never touches the flags.
- OPER reads the register file as of that edge. A load landing on the OPER edge is not seen by the instruction; a load any earlier is seen.
- Reset asserted mid-instruction aborts it immediately: no writeback, no done, and all state returns to its reset values.

## Timing
- Handshake: transfer on the rising edge where instr_valid & instr_ready. instr_ready is low from the accept edge until the WB->IDLE edge.
- Latency, with the accept at edge E0:
  - E1 registers the ALU inputs.
  - E2 samples the ALU outputs.
  - E3 writes back and updates flags.
  - done is high for the single cycle between E3 and E4.
- Throughput: one instruction per 4 cycles. The next instruction may be accepted at E4, while done is high.
- The ALU is purely combinational. Its outputs must settle within the single EXEC cycle.
- dbg_data reflects writes from the edge after they occur.

## Test plan
- Reset: with rst high mid-cycle, dbg_data = 0x00 at every address, flags 000, done 0, instr_ready 1. After release, no spurious activity.
- ADD overflow: load R0=0x7F, R1=0x01; issue op 4, rd 0, rs 1. Expect alu_a=0x7F and alu_b=0x01 after E1, done at E3+1, R0=0x80, V=1, Z=0, R1 unchanged.
- SUB to zero with immediate: R2=0x05; issue op 5, rd 2, use_imm 1, imm 0x05. Expect R2=0x00, Z=1, V=0.
- NOP and reserved op: with flags from the previous test, issue op 9 and then op 12, rd 2. Expect done pulses each time, R2 and flags unchanged.
- Backpressure: hold instr_valid high with two different instructions back-to-back. Expect the second to be accepted exactly at E4 of the first, instr_ready low in between, and both results correct.
- Load collision and reset abort:
  - During WB of an op 8 (MOV imm 0xAA, rd 1), also assert load_en to address 1 with 0x55. Expect R1=0xAA.
  - Assert rst during EXEC of a later instruction. Expect no writeback, no done, and all registers 0x00.

Source files
------------

// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake and ALU operand/result bus for alu_exec_ctrl.
// master: instruction source plus the combinational ALU it feeds.
// slave : the execute-stage controller (alu_exec_ctrl).
interface alu_exec_ctrl_if;
    // Decoded instruction, valid/ready handshake
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs;
    logic       instr_use_imm;
    logic [7:0] instr_imm;
    logic       instr_use_carry;

    // Registered ALU inputs
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic       alu_cin;

    // Combinational ALU outputs
    logic [7:0] alu_res;
    logic       alu_cout;
    logic       alu_zero;
    logic       alu_ovf;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs,
               instr_use_imm, instr_imm, instr_use_carry,
        input  instr_ready,
        input  alu_a, alu_b, alu_op, alu_cin,
        output alu_res, alu_cout, alu_zero, alu_ovf
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs,
               instr_use_imm, instr_imm, instr_use_carry,
        output instr_ready,
        output alu_a, alu_b, alu_op, alu_cin,
        input  alu_res, alu_cout, alu_zero, alu_ovf
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: register file, operand staging, ALU result writeback, C/Z/V flags.
// Latency: accept at E0, ALU inputs at E1, ALU outputs sampled at E2, writeback at E3, done pulse E3..E4.
// Backpressure: instr_ready high only in IDLE; one instruction every 4 cycles, next accept at E4.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   bus (slave)        instruction handshake + ALU operand/result bus
//   done               one-cycle retire pulse
//   flag_c/z/v         architectural flags
//   load_en/addr/data  external register-file write port (any state)
//   dbg_addr/dbg_data  combinational register-file read port
module alu_exec_ctrl (
    input  logic             clk,
    input  logic             rst,
    alu_exec_ctrl_if.slave   bus,
    output logic             done,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
    input  logic             load_en,
    input  logic [1:0]       load_addr,
    input  logic [7:0]       load_data,
    input  logic [1:0]       dbg_addr,
    output logic [7:0]       dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPER = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Opcodes 0..8 write back; 9 (NOP) and reserved 10..15 retire silently.
    localparam logic [3:0] LAST_WRITING_OP = 4'd8;

    state_t     state;
    logic [7:0] rf [4];

    // Latched instruction fields
    logic [3:0] lat_op;
    logic [1:0] lat_rd;
    logic [1:0] lat_rs;
    logic       lat_use_imm;
    logic [7:0] lat_imm;
    logic       lat_use_carry;

    // ALU result/flag holding registers (captured in EXEC)
    logic [7:0] res_q;
    logic       cout_q;
    logic       zero_q;
    logic       ovf_q;

    // ALU operand registers, held between instructions
    logic [7:0] alu_a_q;
    logic [7:0] alu_b_q;
    logic [3:0] alu_op_q;
    logic       alu_cin_q;

    assign bus.alu_a   = alu_a_q;
    assign bus.alu_b   = alu_b_q;
    assign bus.alu_op  = alu_op_q;
    assign bus.alu_cin = alu_cin_q;

    assign bus.instr_ready = (state == ST_IDLE);
    assign dbg_data        = rf[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            for (int i = 0; i < 4; i++) begin
                rf[i] <= 8'h00;
            end
            lat_op        <= 4'd0;
            lat_rd        <= 2'd0;
            lat_rs        <= 2'd0;
            lat_use_imm   <= 1'b0;
            lat_imm       <= 8'h00;
            lat_use_carry <= 1'b0;
            res_q         <= 8'h00;
            cout_q        <= 1'b0;
            zero_q        <= 1'b0;
            ovf_q         <= 1'b0;
            alu_a_q       <= 8'h00;
            alu_b_q       <= 8'h00;
            alu_op_q      <= 4'd0;
            alu_cin_q     <= 1'b0;
            flag_c        <= 1'b0;
            flag_z        <= 1'b0;
            flag_v        <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;

            // External load first: a writeback to the same address later
            // in this block overrides it on the same edge.
            if (load_en) begin
                rf[load_addr] <= load_data;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        lat_op        <= bus.instr_op;
                        lat_rd        <= bus.instr_rd;
                        lat_rs        <= bus.instr_rs;
                        lat_use_imm   <= bus.instr_use_imm;
                        lat_imm       <= bus.instr_imm;
                        lat_use_carry <= bus.instr_use_carry;
                        state         <= ST_OPER;
                    end
                end

                ST_OPER: begin
                    // rf read here is the pre-edge contents, so a load on
                    // this same edge is not visible to the instruction.
                    alu_a_q   <= rf[lat_rd];
                    alu_b_q   <= lat_use_imm ? lat_imm : rf[lat_rs];
                    alu_op_q  <= lat_op;
                    alu_cin_q <= lat_use_carry & flag_c;
                    state     <= ST_EXEC;
                end

                ST_EXEC: begin
                    res_q  <= bus.alu_res;
                    cout_q <= bus.alu_cout;
                    zero_q <= bus.alu_zero;
                    ovf_q  <= bus.alu_ovf;
                    state  <= ST_WB;
                end

                ST_WB: begin
                    if (lat_op <= LAST_WRITING_OP) begin
                        rf[lat_rd] <= res_q;
                        flag_c     <= cout_q;
                        flag_z     <= zero_q;
                        flag_v     <= ovf_q;
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
`timescale 1ns/100ps
module tb_alu_exec_ctrl;

    typedef struct {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       use_imm;
        logic [7:0] imm;
        logic       use_carry;
    } instr_t;

    typedef struct {
        logic [7:0] pa;        // preload of rd
        logic [7:0] pb;        // preload of rs (when a register operand)
        instr_t     ins;
        logic [7:0] exp_rd;
        logic [2:0] exp_flags; // {C,Z,V}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done;
    logic       flag_c, flag_z, flag_v;
    logic       load_en = 1'b0;
    logic [1:0] load_addr = 2'd0;
    logic [7:0] load_data = 8'h00;
    logic [1:0] dbg_addr = 2'd0;
    logic [7:0] dbg_data;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state
    logic [7:0] m_reg [4];
    logic       m_c, m_z, m_v;

    alu_exec_ctrl_if bus();

    alu_exec_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .done      (done),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    // Combinational ALU: returns {cout, zero, ovf, res}
    function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op, input logic cin);
        logic [8:0] t;
        logic [7:0] r;
        logic       c, v;
        t = 9'd0; r = 8'h00; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~a;
            4'd4: begin
                t = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                r = t[7:0]; c = t[8]; v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd5: begin
                t = {1'b0, a} - {1'b0, b} - {8'd0, cin};
                r = t[7:0]; c = t[8]; v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd6: begin
                t = {1'b0, a} + 9'd1;
                r = t[7:0]; c = t[8]; v = (a == 8'h7F);
            end
            4'd7: begin
                t = {1'b0, a} - 9'd1;
                r = t[7:0]; c = t[8]; v = (a == 8'h80);
            end
            4'd8: r = b;
            default: r = 8'h00;
        endcase
        return {c, (r == 8'h00), v, r};
    endfunction

    always_comb begin
        {bus.alu_cout, bus.alu_zero, bus.alu_ovf, bus.alu_res} =
            alu_f(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_c = 1'b0; m_z = 1'b0; m_v = 1'b0;
    endtask

    // Compare every register and the flags with the reference
    task automatic check_all(input string tag);
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #0.2;
            chk($sformatf("%s_r%0d", tag, a), {24'd0, dbg_data}, {24'd0, m_reg[a]});
        end
        chk({tag, "_flags"}, {29'd0, flag_c, flag_z, flag_v}, {29'd0, m_c, m_z, m_v});
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        dbg_addr = a;
        #0.2;
        d = dbg_data;
    endtask

    // Called just after a rising edge; writes one register
    task automatic load(input logic [1:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        m_reg[a] = d;
    endtask

    task automatic drive_instr(input instr_t i);
        bus.instr_op        = i.op;
        bus.instr_rd        = i.rd;
        bus.instr_rs        = i.rs;
        bus.instr_use_imm   = i.use_imm;
        bus.instr_imm       = i.imm;
        bus.instr_use_carry = i.use_carry;
    endtask

    // Runs one instruction end to end. le selects the edge (0..3 = E0..E3)
    // carrying a concurrent external load, -1 for none.
    task automatic exec(input string tag, input instr_t i, input int le,
                        input logic [1:0] la, input logic [7:0] ld);
        logic [7:0]  ea, eb;
        logic        ecin;
        logic [10:0] r;
        bit          acc;
        acc = 0;

        // Reference: loads on E0 are seen, loads after the operand read are not,
        // and a same-address load on the writeback edge loses to writeback.
        if (le == 0) m_reg[la] = ld;
        ea   = m_reg[i.rd];
        eb   = i.use_imm ? i.imm : m_reg[i.rs];
        ecin = i.use_carry & m_c;
        if (le >= 1) m_reg[la] = ld;
        r = alu_f(ea, eb, i.op, ecin);
        if (i.op <= 4'd8) begin
            m_reg[i.rd] = r[7:0];
            {m_c, m_z, m_v} = r[10:8];
        end

        drive_instr(i);
        bus.instr_valid = 1'b1;
        load_en = (le == 0); load_addr = la; load_data = ld;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (bus.instr_ready) acc = 1;
            @(posedge clk);
        end
        #1;
        bus.instr_valid = 1'b0;
        chk({tag, "_accept"}, {31'd0, acc}, 32'd1);
        if (!acc) begin
            load_en = 1'b0;
            return;
        end
        load_en = (le == 1);
        @(posedge clk); #1;                          // after E1
        load_en = (le == 2);
        chk({tag, "_alu_a"},   {24'd0, bus.alu_a},   {24'd0, ea});
        chk({tag, "_alu_b"},   {24'd0, bus.alu_b},   {24'd0, eb});
        chk({tag, "_alu_op"},  {28'd0, bus.alu_op},  {28'd0, i.op});
        chk({tag, "_alu_cin"}, {31'd0, bus.alu_cin}, {31'd0, ecin});
        chk({tag, "_rdy_busy"}, {31'd0, bus.instr_ready}, 32'd0);
        @(posedge clk); #1;                          // after E2
        load_en = (le == 3);
        chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
        @(posedge clk); #1;                          // after E3
        load_en = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        check_all(tag);
    endtask

    function automatic instr_t mk(input logic [3:0] op, input logic [1:0] rd,
                                  input logic [1:0] rs, input logic ui,
                                  input logic [7:0] imm, input logic uc);
        instr_t i;
        i.op = op; i.rd = rd; i.rs = rs; i.use_imm = ui; i.imm = imm; i.use_carry = uc;
        return i;
    endfunction

    vec_t vecs [12];

    initial begin : main
        logic [7:0] d;
        int         done_cnt;
        instr_t     ia, ib;

        bus.instr_valid = 1'b0;
        drive_instr(mk(4'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0));
        model_reset();

        // Table: rd=0, rs=1 unless noted; flags {C,Z,V}
        vecs[0]  = '{8'hF0, 8'h3C, mk(4'd0, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0), 8'h30, 3'b000};
        vecs[1]  = '{8'h00, 8'h00, mk(4'd1, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0), 8'h00, 3'b010};
        vecs[2]  = '{8'hAA, 8'hAA, mk(4'd2, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0), 8'h00, 3'b010};
        vecs[3]  = '{8'h0F, 8'h00, mk(4'd3, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0), 8'hF0, 3'b000};
        vecs[4]  = '{8'h7F, 8'h01, mk(4'd4, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0), 8'h80, 3'b001};
        vecs[5]  = '{8'hFF, 8'h01, mk(4'd4, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0), 8'h00, 3'b110};
        vecs[6]  = '{8'h00, 8'h01, mk(4'd5, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0), 8'hFF, 3'b100};
        vecs[7]  = '{8'h80, 8'h01, mk(4'd5, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0), 8'h7F, 3'b001};
        vecs[8]  = '{8'hFF, 8'h00, mk(4'd6, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0), 8'h00, 3'b110};
        vecs[9]  = '{8'h00, 8'h00, mk(4'd7, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0), 8'hFF, 3'b100};
        vecs[10] = '{8'h11, 8'h00, mk(4'd8, 2'd0, 2'd1, 1'b1, 8'h5A, 1'b0), 8'h5A, 3'b000};
        vecs[11] = '{8'h05, 8'h00, mk(4'd5, 2'd2, 2'd0, 1'b1, 8'h05, 1'b0), 8'h00, 3'b010};

        // Reset state, checked mid-cycle with rst high
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_done",  {31'd0, done}, 32'd0);
        chk("reset_ready", {31'd0, bus.instr_ready}, 32'd1);
        chk("reset_alu", {11'd0, bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        chk("post_reset_no_done", done_cnt, 0);
        chk("post_reset_ready", {31'd0, bus.instr_ready}, 32'd1);

        // Table-driven vectors
        for (int k = 0; k < 12; k++) begin
            load(vecs[k].ins.rd, vecs[k].pa);
            if (!vecs[k].ins.use_imm && vecs[k].ins.rs != vecs[k].ins.rd)
                load(vecs[k].ins.rs, vecs[k].pb);
            exec($sformatf("vec%0d", k), vecs[k].ins, -1, 2'd0, 8'h00);
            read_reg(vecs[k].ins.rd, d);
            chk($sformatf("vec%0d_exp_rd", k), {24'd0, d}, {24'd0, vecs[k].exp_rd});
            chk($sformatf("vec%0d_exp_flags", k), {29'd0, flag_c, flag_z, flag_v},
                {29'd0, vecs[k].exp_flags});
        end

        // NOP and reserved op: done pulses, R2 and flags (Z=1) untouched
        exec("nop",  mk(4'd9,  2'd2, 2'd0, 1'b0, 8'h00, 1'b0), -1, 2'd0, 8'h00);
        exec("rsvd", mk(4'd12, 2'd2, 2'd1, 1'b1, 8'h33, 1'b1), -1, 2'd0, 8'h00);
        chk("rsvd_flags_held", {29'd0, flag_c, flag_z, flag_v}, 32'b010);

        // Carry-in path: produce C=1, then ADD with carry
        load(2'd3, 8'hFF);
        exec("mkcarry", mk(4'd6, 2'd3, 2'd0, 1'b0, 8'h00, 1'b0), -1, 2'd0, 8'h00);
        exec("addc", mk(4'd4, 2'd0, 2'd1, 1'b1, 8'h10, 1'b1), -1, 2'd0, 8'h00);

        // Load on the OPER edge is not seen; load on the accept edge is
        load(2'd3, 8'h10);
        load(2'd0, 8'h01);
        exec("ld_oper", mk(4'd1, 2'd3, 2'd0, 1'b0, 8'h00, 1'b0), 1, 2'd3, 8'h40);
        read_reg(2'd3, d);
        chk("ld_oper_r3", {24'd0, d}, 32'h11);
        exec("ld_acc", mk(4'd1, 2'd3, 2'd0, 1'b0, 8'h00, 1'b0), 0, 2'd3, 8'h40);
        read_reg(2'd3, d);
        chk("ld_acc_r3", {24'd0, d}, 32'h41);

        // Writeback beats same-address load; different address loads both land
        exec("collide", mk(4'd8, 2'd1, 2'd0, 1'b1, 8'hAA, 1'b0), 3, 2'd1, 8'h55);
        read_reg(2'd1, d);
        chk("collide_r1", {24'd0, d}, 32'hAA);
        exec("wb_other", mk(4'd8, 2'd1, 2'd0, 1'b1, 8'hC3, 1'b0), 3, 2'd2, 8'h66);

        // Back-to-back with instr_valid held high
        ia = mk(4'd4, 2'd1, 2'd2, 1'b0, 8'h00, 1'b0);
        ib = mk(4'd2, 2'd2, 2'd0, 1'b1, 8'h0F, 1'b0);
        drive_instr(ia);
        bus.instr_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready0", {31'd0, bus.instr_ready}, 32'd1);
        @(posedge clk); #1;                                  // E0 of A
        begin
            logic [10:0] r;
            r = alu_f(m_reg[1], m_reg[2], 4'd4, 1'b0);
            m_reg[1] = r[7:0];
            {m_c, m_z, m_v} = r[10:8];
        end
        drive_instr(ib);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_busy%0d", k), {31'd0, bus.instr_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("bp_a_done", {31'd0, done}, 32'd1);
        chk("bp_a_ready", {31'd0, bus.instr_ready}, 32'd1);
        check_all("bp_a");
        @(posedge clk); #1;                                  // E4: B accepted
        bus.instr_valid = 1'b0;
        chk("bp_b_taken", {31'd0, bus.instr_ready}, 32'd0);
        begin
            logic [10:0] r;
            r = alu_f(m_reg[2], 8'h0F, 4'd2, 1'b0);
            m_reg[2] = r[7:0];
            {m_c, m_z, m_v} = r[10:8];
        end
        repeat (3) @(posedge clk);
        #1;
        chk("bp_b_done", {31'd0, done}, 32'd1);
        check_all("bp_b");
        @(posedge clk); #1;
        chk("bp_idle", {31'd0, bus.instr_ready}, 32'd1);

        // Randomized instructions against the reference model
        for (int n = 0; n < 40; n++) begin
            instr_t ri;
            if ($urandom_range(0, 3) == 0)
                load(2'($urandom_range(0, 3)), 8'($urandom));
            ri = mk(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 1'($urandom));
            exec($sformatf("rnd%0d", n), ri, $urandom_range(0, 4) - 1,
                 2'($urandom_range(0, 3)), 8'($urandom));
        end

        // Reset during EXEC aborts the instruction
        load(2'd0, 8'h3C);
        drive_instr(mk(4'd8, 2'd0, 2'd0, 1'b1, 8'hEE, 1'b0));
        bus.instr_valid = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
        @(posedge clk); #1;                                  // E0
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;                                  // EXEC
        rst = 1'b1;
        model_reset();
        #1;
        check_all("abort");
        chk("abort_done",  {31'd0, done}, 32'd0);
        chk("abort_ready_rst", {31'd0, bus.instr_ready}, 32'd1);
        chk("abort_alu", {11'd0, bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        check_all("abort_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
